// File: rtl/id_regfile_bypass.sv
// ID-stage operand block: 32x32 register file (two async read ports, one
// sync write port) followed by two 4:1 operand-select muxes that pick either
// the register value or one of the EX/MEM/MEM-load bypass values.
module id_regfile_bypass #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic             we,
  input  logic [AW-1:0]    rna,
  input  logic [AW-1:0]    rnb,
  input  logic [AW-1:0]    wn,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] ans_ex,
  input  logic [WIDTH-1:0] ans_me,
  input  logic [WIDTH-1:0] mo_me,
  input  logic [1:0]       a_select,
  input  logic [1:0]       b_select,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  // Four-way operand source select shared by the A and B paths.
  function automatic logic [WIDTH-1:0] select_4(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] reg_val,
    input logic [WIDTH-1:0] ex_val,
    input logic [WIDTH-1:0] me_val,
    input logic [WIDTH-1:0] mo_val
  );
    logic [WIDTH-1:0] result;
    case (sel)
      2'b00:   result = reg_val;
      2'b01:   result = ex_val;
      2'b10:   result = me_val;
      default: result = mo_val;
    endcase
    return result;
  endfunction

  // Next register state: only the addressed entry changes, and entry 0 is pinned to zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (we && (wn == AW'(i)) && (i != 0)) begin
        regs_d[i] = d;
      end
    end
    regs_d[0] = '0;
  end

  // Register storage; the async clear also blocks writes while reset is held.
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational reads with no write-through: a write shows up only after its edge.
  always_comb begin
    qa = regs_q[rna];
    qb = regs_q[rnb];
  end

  // Operand selection; EX-vs-MEM priority is resolved upstream in the control block.
  always_comb begin
    a_out = select_4(a_select, qa, ans_ex, ans_me, mo_me);
    b_out = select_4(b_select, qb, ans_ex, ans_me, mo_me);
  end

endmodule

// File: tb/tb_id_regfile_bypass.sv
// Self-checking bench for id_regfile_bypass: hand-written sequences for
// reset, write, R0 and same-address timing, plus a vector table for the muxes.
module tb_id_regfile_bypass;

  logic        clock;
  logic        reset_0;
  logic        we;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [31:0] ans_ex;
  logic [31:0] ans_me;
  logic [31:0] mo_me;
  logic [1:0]  a_select;
  logic [1:0]  b_select;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [31:0] a_out;
  logic [31:0] b_out;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] ex;
    logic [31:0] me;
    logic [31:0] mo;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[8];

  id_regfile_bypass #(.WIDTH(32), .AW(5)) dut (
    .clock    (clock),
    .reset_0  (reset_0),
    .we       (we),
    .rna      (rna),
    .rnb      (rnb),
    .wn       (wn),
    .d        (d),
    .ans_ex   (ans_ex),
    .ans_me   (ans_me),
    .mo_me    (mo_me),
    .a_select (a_select),
    .b_select (b_select),
    .qa       (qa),
    .qb       (qb),
    .a_out    (a_out),
    .b_out    (b_out)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Wait for the next rising edge and settle just past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One write cycle through the WB port, then deassert the enable.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    we = 1'b1;
    wn = addr;
    d  = data;
    tick();
    we = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    a_select = v.a_sel;
    b_select = v.b_sel;
    ans_ex   = v.ex;
    ans_me   = v.me;
    mo_me    = v.mo;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_0  = 1'b0;
    we       = 1'b0;
    rna      = 5'd5;
    rnb      = 5'd31;
    wn       = 5'd0;
    d        = 32'h0;
    ans_ex   = 32'h0;
    ans_me   = 32'h0;
    mo_me    = 32'h0;
    a_select = 2'b00;
    b_select = 2'b00;

    vecs[0] = '{2'd0, 2'd0, 32'h22,       32'h33,       32'h44, 32'h11,       32'h55};
    vecs[1] = '{2'd1, 2'd1, 32'h22,       32'h33,       32'h44, 32'h22,       32'h22};
    vecs[2] = '{2'd2, 2'd2, 32'h22,       32'h33,       32'h44, 32'h33,       32'h33};
    vecs[3] = '{2'd3, 2'd3, 32'h22,       32'h33,       32'h44, 32'h44,       32'h44};
    vecs[4] = '{2'd1, 2'd3, 32'h22,       32'h33,       32'h44, 32'h22,       32'h44};
    vecs[5] = '{2'd3, 2'd0, 32'h22,       32'h33,       32'h44, 32'h44,       32'h55};
    vecs[6] = '{2'd2, 2'd1, 32'hCAFEF00D, 32'h12345678, 32'h0,  32'h12345678, 32'hCAFEF00D};
    vecs[7] = '{2'd0, 2'd2, 32'h0,        32'hFFFFFFFF, 32'h1,  32'h11,       32'hFFFFFFFF};

    // Reset state
    #2;
    check_output("reset qa r5", qa, 32'h0);
    check_output("reset qb r31", qb, 32'h0);
    check_output("reset a_out", a_out, 32'h0);
    tick();
    reset_0 = 1'b1;
    tick();

    // Async reset clears a written register without a clock edge
    write_reg(5'd5, 32'h1234);
    rna = 5'd5;
    #1;
    check_output("write r5", qa, 32'h1234);
    #2;
    reset_0 = 1'b0;
    #1;
    check_output("async reset r5", qa, 32'h0);

    // Writes are blocked while reset is held
    write_reg(5'd6, 32'h55);
    rna = 5'd6;
    #1;
    reset_0 = 1'b1;
    #1;
    check_output("write during reset r6", qa, 32'h0);
    rna = 5'd5;
    #1;
    check_output("r5 after release", qa, 32'h0);

    // Write then read on both ports; a disabled write leaves the value alone
    write_reg(5'd7, 32'hDEADBEEF);
    rna = 5'd7;
    rnb = 5'd7;
    #1;
    check_output("r7 qa", qa, 32'hDEADBEEF);
    check_output("r7 qb", qb, 32'hDEADBEEF);
    we = 1'b0;
    wn = 5'd7;
    d  = 32'h1;
    tick();
    check_output("r7 we=0 qa", qa, 32'hDEADBEEF);

    // Register 0 discards writes
    write_reg(5'd0, 32'hFFFFFFFF);
    rna = 5'd0;
    #1;
    check_output("r0 qa", qa, 32'h0);
    check_output("r0 a_out", a_out, 32'h0);

    // Top address is writable
    write_reg(5'd31, 32'h31313131);
    rnb = 5'd31;
    #1;
    check_output("r31 qb", qb, 32'h31313131);

    // Same-address read/write: old value before the edge, new value after
    write_reg(5'd3, 32'h0BAD0003);
    rna = 5'd3;
    rnb = 5'd3;
    wn  = 5'd3;
    d   = 32'hA5A5A5A5;
    we  = 1'b1;
    #1;
    check_output("r3 qa before edge", qa, 32'h0BAD0003);
    check_output("r3 qb before edge", qb, 32'h0BAD0003);
    tick();
    we = 1'b0;
    check_output("r3 qa after edge", qa, 32'hA5A5A5A5);
    check_output("r3 qb after edge", qb, 32'hA5A5A5A5);

    // Mux table: register A source holds 0x11, register B source holds 0x55
    write_reg(5'd9, 32'h11);
    write_reg(5'd10, 32'h55);
    rna = 5'd9;
    rnb = 5'd10;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d qa", i), qa, 32'h11);
      check_output($sformatf("vec%0d qb", i), qb, 32'h55);
      check_output($sformatf("vec%0d a_out", i), a_out, vecs[i].exp_a);
      check_output($sformatf("vec%0d b_out", i), b_out, vecs[i].exp_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
